// File: rtl/regfile_pkg.sv
// Shared defaults and limits for the multi-port integer register file.
// Build option: define REGFILE_SCOREBOARD_EN to add the issue/busy scoreboard.
package regfile_pkg;

   localparam int          RF_DATAWIDTH = 32;
   localparam int          RF_NUM_REGS  = 32;
   localparam int          RF_ADDRWIDTH = 5;
   localparam int unsigned RF_ZERO_IDX  = 0;
   localparam int          RF_MAX_RD    = 4;
   localparam int          RF_MAX_WR    = 2;

   // An index names a writable register only if it is not x0 and exists.
   function automatic logic rf_idx_valid(input int unsigned idx, input int unsigned num_regs);
      return (idx != RF_ZERO_IDX) && (idx < num_regs);
   endfunction

endpackage

// File: rtl/regfile_wr_merge.sv
// Combinational write-port merge for one register index: reports whether any
// enabled write port targets the index, the value that wins, and which port won.
// Later (higher-index) ports override earlier ones. Invalid indices never hit.
// Build option: none (REGFILE_SCOREBOARD_EN is handled in the top level).
module regfile_wr_merge
   import regfile_pkg::*;
#(
   parameter int DATAWIDTH = RF_DATAWIDTH,
   parameter int NUM_REGS  = RF_NUM_REGS,
   parameter int ADDRWIDTH = RF_ADDRWIDTH,
   parameter int NUM_WR    = 1
) (
   input  logic [NUM_WR-1:0]           wr_en_i,
   input  logic [NUM_WR*ADDRWIDTH-1:0] wr_addr_i,
   input  logic [NUM_WR*DATAWIDTH-1:0] wr_data_i,
   input  logic [ADDRWIDTH-1:0]        idx_i,
   output logic                        hit_o,
   output logic [DATAWIDTH-1:0]        data_o,
   output logic                        port_o
);

   // Scan ports in ascending order so the highest matching port is the last assignment.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      port_o = 1'b0;
      if (rf_idx_valid(32'(idx_i), NUM_REGS)) begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*ADDRWIDTH +: ADDRWIDTH] == idx_i)) begin
               hit_o  = 1'b1;
               data_o = wr_data_i[w*DATAWIDTH +: DATAWIDTH];
               port_o = 1'(w);
            end
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: x0 reads as zero, registered reads with
// write-first bypass, per-port read enable that holds the output during stalls.
// Build option: define REGFILE_SCOREBOARD_EN to add iss_en/iss_addr/rd_busy and
// a per-register busy bit (set on issue, cleared on writeback, issue wins).
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATAWIDTH = RF_DATAWIDTH,
   parameter int NUM_REGS  = RF_NUM_REGS,
   parameter int ADDRWIDTH = RF_ADDRWIDTH,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_RD-1:0]           rd_en,
   input  logic [NUM_RD*ADDRWIDTH-1:0] rd_addr,
   input  logic [NUM_WR-1:0]           wr_en,
   input  logic [NUM_WR*ADDRWIDTH-1:0] wr_addr,
   input  logic [NUM_WR*DATAWIDTH-1:0] wr_data,
`ifdef REGFILE_SCOREBOARD_EN
   input  logic                        iss_en,
   input  logic [ADDRWIDTH-1:0]        iss_addr,
   output logic [NUM_RD-1:0]           rd_busy,
`endif
   output logic [NUM_RD*DATAWIDTH-1:0] rd_data
);

   if (NUM_REGS < 2 || NUM_RD < 1 || NUM_RD > RF_MAX_RD || NUM_WR < 1 || NUM_WR > RF_MAX_WR
       || ADDRWIDTH < $clog2(NUM_REGS)) begin : g_param_check
      $error("regfile_mp: illegal parameter combination");
   end

   logic [DATAWIDTH-1:0] regs_q    [NUM_REGS];
   logic [NUM_REGS-1:0]  wr_hit;
   logic [DATAWIDTH-1:0] wr_val    [NUM_REGS];
   logic [NUM_RD-1:0]    rd_hit;
   logic [DATAWIDTH-1:0] rd_byp    [NUM_RD];
   logic [DATAWIDTH-1:0] rd_data_d [NUM_RD];
   logic [DATAWIDTH-1:0] rd_data_q [NUM_RD];
   // The winning port number is only of interest to other clients of the merge.
   logic [NUM_REGS-1:0]  st_port_unused;
   logic [NUM_RD-1:0]    rd_port_unused;

   // One merge per register resolves that register's next value.
   for (genvar r = 0; r < NUM_REGS; r++) begin : g_store
      regfile_wr_merge #(
         .DATAWIDTH (DATAWIDTH),
         .NUM_REGS  (NUM_REGS),
         .ADDRWIDTH (ADDRWIDTH),
         .NUM_WR    (NUM_WR)
      ) u_st_merge (
         .wr_en_i   (wr_en),
         .wr_addr_i (wr_addr),
         .wr_data_i (wr_data),
         .idx_i     (ADDRWIDTH'(r)),
         .hit_o     (wr_hit[r]),
         .data_o    (wr_val[r]),
         .port_o    (st_port_unused[r])
      );
   end

   // One merge per read port forwards a same-cycle write to the read address.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      regfile_wr_merge #(
         .DATAWIDTH (DATAWIDTH),
         .NUM_REGS  (NUM_REGS),
         .ADDRWIDTH (ADDRWIDTH),
         .NUM_WR    (NUM_WR)
      ) u_rd_merge (
         .wr_en_i   (wr_en),
         .wr_addr_i (wr_addr),
         .wr_data_i (wr_data),
         .idx_i     (rd_addr[p*ADDRWIDTH +: ADDRWIDTH]),
         .hit_o     (rd_hit[p]),
         .data_o    (rd_byp[p]),
         .port_o    (rd_port_unused[p])
      );
      assign rd_data[p*DATAWIDTH +: DATAWIDTH] = rd_data_q[p];
   end

   // Storage update; x0 never hits, so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_hit[r]) regs_q[r] <= wr_val[r];
         end
      end
   end

   // Read value as seen after this edge's writes: bypass, else storage, else zero.
   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         rd_data_d[p] = '0;
         if (rd_hit[p]) begin
            rd_data_d[p] = rd_byp[p];
         end else if (rf_idx_valid(32'(rd_addr[p*ADDRWIDTH +: ADDRWIDTH]), NUM_REGS)) begin
            rd_data_d[p] = regs_q[rd_addr[p*ADDRWIDTH +: ADDRWIDTH]];
         end
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_RD-1:0]   rd_busy_d;
   logic [NUM_RD-1:0]   rd_busy_q;

   assign rd_busy = rd_busy_q;

   // Busy next state: a write clears, an issue sets, and issue wins on the same edge.
   always_comb begin
      busy_d = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         busy_d[r] = (iss_en && (iss_addr == ADDRWIDTH'(r))) || (busy_q[r] && !wr_hit[r]);
      end
   end

   // Busy flag seen by each read port, taken from the post-update busy state.
   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         rd_busy_d[p] = 1'b0;
         if (rf_idx_valid(32'(rd_addr[p*ADDRWIDTH +: ADDRWIDTH]), NUM_REGS)) begin
            rd_busy_d[p] = busy_d[rd_addr[p*ADDRWIDTH +: ADDRWIDTH]];
         end
      end
   end

   // Busy array and read registers; a disabled port holds both data and busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         rd_busy_q <= '0;
         for (int p = 0; p < NUM_RD; p++) rd_data_q[p] <= '0;
      end else begin
         busy_q <= busy_d;
         for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en[p]) begin
               rd_data_q[p] <= rd_data_d[p];
               rd_busy_q[p] <= rd_busy_d[p];
            end
         end
      end
   end
`else
   // Read registers; a disabled port holds its last data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NUM_RD; p++) rd_data_q[p] <= '0;
      end else begin
         for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en[p]) rd_data_q[p] <= rd_data_d[p];
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp with two read and two write ports.
// Build option: define REGFILE_SCOREBOARD_EN to also exercise the busy scoreboard.
module tb_regfile_mp;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NR  = 28;
   localparam int NRD = 2;
   localparam int NWR = 2;

   // ---------------- clock / reset / signals ----------------
   logic clk = 1'b0;
   logic rst;
   logic [NRD-1:0]    rd_en;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NWR-1:0]    wr_en;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic              iss_en;
   logic [AW-1:0]     iss_addr;
`ifdef REGFILE_SCOREBOARD_EN
   logic [NRD-1:0]    rd_busy;
`endif

   always #5 clk = ~clk;

   regfile_mp #(
      .DATAWIDTH (DW),
      .NUM_REGS  (NR),
      .ADDRWIDTH (AW),
      .NUM_RD    (NRD),
      .NUM_WR    (NWR)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
`ifdef REGFILE_SCOREBOARD_EN
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .rd_busy  (rd_busy),
`endif
      .rd_data  (rd_data)
   );

   // ---------------- reference model and scoreboard ----------------
   logic [DW-1:0] m_regs [32];
   logic          m_busy [32];
   logic [DW:0]   m_out  [NRD];      // {busy, data} currently held by each port
   logic [DW:0]   exp_q[$];          // one entry per port per clocked cycle

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;
   bit done     = 1'b0;

   function automatic bit addr_ok(input int a);
      return (a != 0) && (a < NR);
   endfunction

   // Architectural effect of one clock edge, applied to the current inputs.
   task automatic model_step();
      logic [DW-1:0] nregs [32];
      logic          nbusy [32];
      int a;
      nregs = m_regs;
      nbusy = m_busy;
      for (int w = 0; w < NWR; w++) begin
         a = int'(wr_addr[w*AW +: AW]);
         if (wr_en[w] && addr_ok(a)) begin
            nregs[a] = wr_data[w*DW +: DW];
            nbusy[a] = 1'b0;
         end
      end
      if (iss_en && addr_ok(int'(iss_addr))) nbusy[int'(iss_addr)] = 1'b1;
      for (int p = 0; p < NRD; p++) begin
         a = int'(rd_addr[p*AW +: AW]);
         if (rd_en[p]) m_out[p] = addr_ok(a) ? {nbusy[a], nregs[a]} : '0;
         exp_q.push_back(m_out[p]);
      end
      m_regs = nregs;
      m_busy = nbusy;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      for (int p = 0; p < NRD; p++) m_out[p] = '0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic [NRD-1:0] ren, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                      input logic [NWR-1:0] wen, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                      input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                      input logic ien, input logic [AW-1:0] ia);
      rd_en    = ren;
      rd_addr  = {ra1, ra0};
      wr_en    = wen;
      wr_addr  = {wa1, wa0};
      wr_data  = {wd1, wd0};
      iss_en   = ien;
      iss_addr = ia;
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset between edges, with a write pending that must be lost.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rd_en   = '1;
      wr_en   = '1;
      wr_addr = {AW'(6), AW'(4)};
      wr_data = {32'h0BAD_0006, 32'h0BAD_0004};
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (rd_data !== '0) begin
         n_fail++;
         $display("FAIL reset_rd_data got %h expected 0 at %0t", rd_data, $time);
      end
`ifdef REGFILE_SCOREBOARD_EN
      n_checks++;
      if (rd_busy !== '0) begin
         n_fail++;
         $display("FAIL reset_rd_busy got %b expected 0 at %0t", rd_busy, $time);
      end
`endif
      @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic         r;
      logic         act;
      logic [DW:0]  e;
      forever begin
         @(posedge clk);
         r   = rst;
         act = mon_en && !done;
         @(negedge clk);
         if (act && !r) begin
            for (int p = 0; p < NRD; p++) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL queue_underflow port %0d at %0t", p, $time);
               end else begin
                  e = exp_q.pop_front();
                  if (rd_data[p*DW +: DW] !== e[DW-1:0]) begin
                     n_fail++;
                     $display("FAIL rd_data[%0d] got %h expected %h at %0t",
                              p, rd_data[p*DW +: DW], e[DW-1:0], $time);
                  end
`ifdef REGFILE_SCOREBOARD_EN
                  n_checks++;
                  if (rd_busy[p] !== e[DW]) begin
                     n_fail++;
                     $display("FAIL rd_busy[%0d] got %b expected %b at %0t",
                              p, rd_busy[p], e[DW], $time);
                  end
`endif
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0; rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0;
      model_reset();
      #1;
      do_reset();
      mon_en = 1'b1;

      // every register reads zero after reset, including out-of-range addresses
      for (int a = 1; a < 32; a += 2) cyc(2'b11, AW'(a), AW'(a + 1), 2'b00, 0, 0, 0, 0, 1'b0, 0);

      // same-cycle write on port 0 is bypassed to read port 1
      cyc(2'b10, 0, 5, 2'b01, 5, 0, 32'hDEAD_BEEF, 0, 1'b0, 0);
      cyc(2'b01, 5, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);

      // x0 is hardwired, and the higher write port wins a collision
      cyc(2'b00, 0, 0, 2'b01, 0, 0, 32'h1234, 0, 1'b0, 0);
      cyc(2'b11, 0, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
      cyc(2'b00, 0, 0, 2'b11, 7, 7, 32'hAAAA, 32'h5555, 1'b0, 0);
      cyc(2'b11, 7, 7, 2'b00, 0, 0, 0, 0, 1'b0, 0);

      // stall hold: disabled port keeps old data while the register changes
      cyc(2'b00, 0, 0, 2'b01, 3, 0, 32'h11, 0, 1'b0, 0);
      cyc(2'b01, 3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
      cyc(2'b00, 3, 0, 2'b01, 3, 0, 32'h22, 0, 1'b0, 0);
      cyc(2'b00, 3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
      cyc(2'b01, 3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);

      // writes beyond the last register are dropped
      cyc(2'b00, 0, 0, 2'b01, 30, 0, 32'hFFFF_FFFF, 0, 1'b0, 0);
      cyc(2'b11, 30, 27, 2'b00, 0, 0, 0, 0, 1'b0, 0);

      // scoreboard: issue sets, same-edge issue+write stays busy, write alone clears
      cyc(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1'b1, 9);
      cyc(2'b11, 9, 9, 2'b00, 0, 0, 0, 0, 1'b0, 0);
      cyc(2'b11, 9, 9, 2'b01, 9, 0, 32'h99, 0, 1'b1, 9);
      cyc(2'b11, 9, 9, 2'b10, 0, 9, 0, 32'h77, 1'b0, 0);

      // reset mid-operation with busy bits set and data held
      cyc(2'b00, 0, 0, 2'b01, 4, 0, 32'h44, 0, 1'b1, 4);
      cyc(2'b11, 4, 6, 2'b00, 0, 0, 0, 0, 1'b1, 6);
      do_reset();
      cyc(2'b11, 4, 6, 2'b00, 0, 0, 0, 0, 1'b0, 0);

      // random traffic, biased toward a few registers to provoke collisions
      for (int i = 0; i < 1500; i++) begin
         logic [AW-1:0] a [5];
         for (int k = 0; k < 5; k++)
            a[k] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
         if (i == 700) do_reset();
         cyc(NRD'($urandom_range(0, 3)), a[0], a[1], NWR'($urandom_range(0, 3)), a[2], a[3],
             $urandom, $urandom, 1'($urandom_range(0, 1)), a[4]);
      end

      @(negedge clk);
      #1;
      done = 1'b1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain got %0d entries expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
